// File: rtl/led_bank_pkg.sv
// led_bank_pkg: opcode constants, controller state encoding and a small
// decode helper shared by led_bank_blink and its testbench-facing top.
package led_bank_pkg;

  localparam int OpBits = 4;

  localparam logic [OpBits-1:0] NOP = 4'd0;
  localparam logic [OpBits-1:0] LDI = 4'd1;
  localparam logic [OpBits-1:0] SET = 4'd2;
  localparam logic [OpBits-1:0] CLR = 4'd3;
  localparam logic [OpBits-1:0] TGL = 4'd4;
  localparam logic [OpBits-1:0] BLK = 4'd5;
  localparam logic [OpBits-1:0] PER = 4'd6;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_READY = 2'd1,
    ST_ERROR = 2'd2
  } state_e;

  // Opcodes whose immediate is a single-LED index and must be range checked.
  function automatic logic is_index_op(input logic [OpBits-1:0] op);
    return (op == SET) || (op == CLR) || (op == TGL);
  endfunction

endpackage

// File: rtl/led_blink_timer.sv
// led_blink_timer: blink phase generator for led_bank_blink.
// Owns the reload down-counter and the lit/dark phase flag. Optional
// prescaler selected by LED_BANK_BLINK_PRESCALE_EN; without it the timer
// advances every cycle.
module led_blink_timer #(
  parameter int Width = 8
`ifdef LED_BANK_BLINK_PRESCALE_EN
  ,
  parameter int PrescaleBits = 16
`endif
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [Width-1:0] period,
  output logic             phase
);

  logic [Width-1:0] count_q;
  logic [Width-1:0] count_d;
  logic             phase_q;
  logic             phase_d;
  logic             tick;

`ifdef LED_BANK_BLINK_PRESCALE_EN
  logic [PrescaleBits-1:0] pre_q;

  // Free-running prescaler; the tick marks the edge on which it wraps to 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_q + PrescaleBits'(1);
    end
  end

  assign tick = (pre_q == '1);
`else
  assign tick = 1'b1;
`endif

  // Next count/phase: a load restarts the lit half and beats the tick.
  always_comb begin
    count_d = count_q;
    phase_d = phase_q;
    if (load) begin
      count_d = period - Width'(1);
      phase_d = 1'b1;
    end else if (enable && tick) begin
      if (period == '0) begin
        count_d = '0;
        phase_d = 1'b1;
      end else if (count_q == '0) begin
        count_d = period - Width'(1);
        phase_d = ~phase_q;
      end else begin
        count_d = count_q - Width'(1);
      end
    end
  end

  // Counter and phase registers; reset starts in the lit half.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
      phase_q <= 1'b1;
    end else begin
      count_q <= count_d;
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/led_bank_blink.sv
// led_bank_blink: instruction-driven LED bank with indexed bit ops and a
// per-LED blink mask. Optional blink prescaler: LED_BANK_BLINK_PRESCALE_EN.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   ST_RESET | first cycle after reset; instructions ignored
//   ST_READY | normal operation; instructions accepted, blink running
//   ST_ERROR | bad opcode or index seen; LEDs dark until reset
module led_bank_blink
  import led_bank_pkg::*;
#(
  parameter int Width   = 8,
  parameter int IdxBits = $clog2(Width)
`ifdef LED_BANK_BLINK_PRESCALE_EN
  ,
  parameter int PrescaleBits = 16
`endif
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [Width+3:0]   inst,
  input  logic               inst_en,
  output logic [Width-1:0]   leds
);

  state_e           state_q;
  state_e           state_d;
  logic [Width-1:0] leds_q;
  logic [Width-1:0] leds_d;
  logic [Width-1:0] blink_q;
  logic [Width-1:0] blink_d;
  logic [Width-1:0] period_q;
  logic [Width-1:0] period_d;

  logic [OpBits-1:0]  opcode;
  logic [Width-1:0]   imm;
  logic [IdxBits-1:0] idx;
  logic               idx_ok;
  logic               load;
  logic [Width-1:0]   timer_period;
  logic               phase;

  assign opcode = inst[Width+3:Width];
  assign imm    = inst[Width-1:0];
  assign idx    = imm[IdxBits-1:0];
  // Whole immediate compared, so stray upper bits are caught as well.
  assign idx_ok = (64'(imm) < 64'(Width));

  // Instruction decode and next-state selection.
  always_comb begin
    state_d  = state_q;
    leds_d   = leds_q;
    blink_d  = blink_q;
    period_d = period_q;
    load     = 1'b0;
    case (state_q)
      ST_RESET: state_d = ST_READY;
      ST_READY: begin
        if (inst_en) begin
          if (is_index_op(opcode) && !idx_ok) begin
            state_d = ST_ERROR;
          end else begin
            case (opcode)
              NOP: ;
              LDI: leds_d = imm;
              SET: leds_d[idx] = 1'b1;
              CLR: leds_d[idx] = 1'b0;
              TGL: leds_d[idx] = ~leds_q[idx];
              BLK: blink_d = imm;
              PER: begin
                period_d = imm;
                load     = 1'b1;
              end
              default: state_d = ST_ERROR;
            endcase
          end
        end
      end
      ST_ERROR: ;
      default: state_d = ST_ERROR;
    endcase
  end

  // Controller state and configuration registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_RESET;
      leds_q   <= '0;
      blink_q  <= '0;
      period_q <= '0;
    end else begin
      state_q  <= state_d;
      leds_q   <= leds_d;
      blink_q  <= blink_d;
      period_q <= period_d;
    end
  end

  // A PER hands the new period straight to the timer so its reload uses it.
  assign timer_period = load ? imm : period_q;

  led_blink_timer #(
    .Width        (Width)
`ifdef LED_BANK_BLINK_PRESCALE_EN
    ,
    .PrescaleBits (PrescaleBits)
`endif
  ) u_timer (
    .clock  (clock),
    .reset  (reset),
    .enable (state_q == ST_READY),
    .load   (load),
    .period (timer_period),
    .phase  (phase)
  );

  assign leds = (state_q == ST_READY) ? (leds_q & ~(blink_q & {Width{~phase}})) : '0;

endmodule
